// File: rtl/msrv32_integer_file_if.sv
// Purpose : bundles the register-file read/write ports between the pipeline and msrv32_integer_file.
// Latency : reads are combinational; writes commit on the next rising clock edge.
// Backpr. : none; the file accepts a write every cycle and reads are always valid.
// Ports   : rs_1/rs_2_addr_in  source indices; rd_addr_in, wr_en_in, rd_in  write port;
//           rs_1_out/rs_2_out  read data.
//           master = pipeline side, slave = register file.
interface msrv32_integer_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs_1_addr_in;
  logic [ADDR_WIDTH-1:0] rs_2_addr_in;
  logic [ADDR_WIDTH-1:0] rd_addr_in;
  logic                  wr_en_in;
  logic [DATA_WIDTH-1:0] rd_in;
  logic [DATA_WIDTH-1:0] rs_1_out;
  logic [DATA_WIDTH-1:0] rs_2_out;

  modport master (
    output rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
    input  rs_1_out, rs_2_out
  );

  modport slave (
    input  rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
    output rs_1_out, rs_2_out
  );
endinterface

// File: rtl/msrv32_integer_file.sv
// Purpose : RV32I integer register file x0..x31 with two async read ports and one sync write port.
// Latency : reads 0 cycles (same-cycle write is bypassed to readers); writes land in the array after 1 edge.
// Backpr. : none; never stalls.
// Ports   : clk_in       core clock, all state changes on rising edge.
//           rst_n_in     synchronous active-low reset; also forces both read ports to 0 while low.
//           rf (slave)   rs_1/rs_2 address + data, rd_addr_in/wr_en_in/rd_in write port.
module msrv32_integer_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  msrv32_integer_file_if.slave rf
);

  // x0 has no storage; reads of index 0 are forced to zero below.
  logic [DATA_WIDTH-1:0] reg_file_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] reg_file_d [1:NUM_REGS-1];

  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] rs_1_dat;
  logic [DATA_WIDTH-1:0] rs_2_dat;

  // A write to x0 is dropped here so it can neither update storage nor bypass.
  assign wr_hit = rf.wr_en_in && (rf.rd_addr_in != '0);

  always_comb begin
    reg_file_d = reg_file_q;
    if (wr_hit) begin
      reg_file_d[rf.rd_addr_in] = rf.rd_in;
    end
  end

  // Reset wins over a coincident write: the write is simply lost.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        reg_file_q[i] <= '0;
      end
    end else begin
      reg_file_q <= reg_file_d;
    end
  end

  // Read port 1: reset, then x0, then same-cycle bypass, then stored value.
  always_comb begin
    rs_1_dat = '0;
    if (!rst_n_in) begin
      rs_1_dat = '0;
    end else if (rf.rs_1_addr_in == '0) begin
      rs_1_dat = '0;
    end else if (wr_hit && (rf.rd_addr_in == rf.rs_1_addr_in)) begin
      rs_1_dat = rf.rd_in;
    end else begin
      rs_1_dat = reg_file_q[rf.rs_1_addr_in];
    end
  end

  // Read port 2: same priority order as port 1, evaluated independently.
  always_comb begin
    rs_2_dat = '0;
    if (!rst_n_in) begin
      rs_2_dat = '0;
    end else if (rf.rs_2_addr_in == '0) begin
      rs_2_dat = '0;
    end else if (wr_hit && (rf.rd_addr_in == rf.rs_2_addr_in)) begin
      rs_2_dat = rf.rd_in;
    end else begin
      rs_2_dat = reg_file_q[rf.rs_2_addr_in];
    end
  end

  assign rf.rs_1_out = rs_1_dat;
  assign rf.rs_2_out = rs_2_dat;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Purpose : self-checking bench for msrv32_integer_file (directed table, sweep, random vs. model).
// Latency : outputs checked on the falling edge of the cycle in which inputs are applied.
// Backpr. : n/a.
module tb_msrv32_integer_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   checks = 0;
  int   errors = 0;

  // Architectural view of the register file: x0 is kept at zero permanently.
  logic [DW-1:0] mdl [32];

  always #5 clk_in = ~clk_in;

  msrv32_integer_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

  msrv32_integer_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rf      (rf_if)
  );

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          wr;
    logic [DW-1:0] din;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst_n, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic wr, input logic [DW-1:0] din);
    rst_n_in           = rst_n;
    rf_if.rs_1_addr_in = rs1;
    rf_if.rs_2_addr_in = rs2;
    rf_if.rd_addr_in   = rd;
    rf_if.wr_en_in     = wr;
    rf_if.rd_in        = din;
  endtask

  // What a reader sees this cycle: a pending non-x0 write to the same register
  // wins, otherwise the committed architectural value; reset forces zero.
  function automatic logic [DW-1:0] visible(input logic [AW-1:0] a);
    if (!rst_n_in) return '0;
    if (rf_if.wr_en_in && rf_if.rd_addr_in == a && a != 0) return rf_if.rd_in;
    return mdl[a];
  endfunction

  // Advance one clock, committing the currently applied inputs to the model.
  task automatic tick();
    @(posedge clk_in);
    if (!rst_n_in) begin
      foreach (mdl[i]) mdl[i] = '0;
    end else if (rf_if.wr_en_in && rf_if.rd_addr_in != 0) begin
      mdl[rf_if.rd_addr_in] = rf_if.rd_in;
    end
    #1;
  endtask

  task automatic run_vec(input string name, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    @(negedge clk_in);
    check({name, ".rs1"}, rf_if.rs_1_out, e1);
    check({name, ".rs2"}, rf_if.rs_2_out, e2);
    tick();
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    apply(1'b0, '0, '0, '0, 1'b0, '0);

    //        rst   rs1    rs2    rd     wr    din            exp rs1        exp rs2
    tbl[0]  = '{1'b0, 5'd5,  5'd31, 5'd0,  1'b0, 32'h0,         32'h0,         32'h0};
    tbl[1]  = '{1'b0, 5'd7,  5'd1,  5'd7,  1'b1, 32'hAAAA_AAAA, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, 5'd5,  5'd31, 5'd0,  1'b0, 32'h0,         32'h0,         32'h0};
    tbl[3]  = '{1'b1, 5'd0,  5'd5,  5'd5,  1'b1, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    tbl[4]  = '{1'b1, 5'd5,  5'd6,  5'd0,  1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0};
    tbl[5]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 5'd0,  5'd5,  5'd0,  1'b0, 32'h0,         32'h0,         32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 5'd7,  5'd5,  5'd7,  1'b1, 32'h1111_1111, 32'h1111_1111, 32'hDEAD_BEEF};
    tbl[8]  = '{1'b1, 5'd7,  5'd7,  5'd7,  1'b0, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111};
    tbl[9]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 32'h0,         32'h1111_1111, 32'h1111_1111};
    tbl[10] = '{1'b1, 5'd7,  5'd7,  5'd7,  1'b1, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222};
    tbl[11] = '{1'b1, 5'd7,  5'd0,  5'd0,  1'b0, 32'h0,         32'h2222_2222, 32'h0};
    tbl[12] = '{1'b1, 5'd3,  5'd3,  5'd3,  1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    tbl[13] = '{1'b1, 5'd3,  5'd5,  5'd0,  1'b0, 32'h0,         32'hA5A5_A5A5, 32'hDEAD_BEEF};
    tbl[14] = '{1'b0, 5'd3,  5'd3,  5'd3,  1'b1, 32'h1234_5678, 32'h0,         32'h0};
    tbl[15] = '{1'b1, 5'd3,  5'd5,  5'd0,  1'b0, 32'h0,         32'h0,         32'h0};
    tbl[16] = '{1'b1, 5'd7,  5'd31, 5'd0,  1'b0, 32'h0,         32'h0,         32'h0};

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst_n, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].din);
      run_vec($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2);
    end

    // Full sweep: fill x1..x31 with (i<<24)|i, then read pairs (i, 32-i).
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, '0, '0, AW'(i), 1'b1, (DW'(i) << 24) | DW'(i));
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, AW'(i), AW'(32 - i), '0, 1'b0, '0);
      run_vec($sformatf("sweep%0d", i),
              (DW'(i) << 24) | DW'(i), (DW'(32 - i) << 24) | DW'(32 - i));
    end

    // Random traffic with addresses concentrated on a few registers so that
    // bypass collisions, x0 accesses and reset-over-write happen often.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] a1, a2, wd;
      logic [DW-1:0] e1, e2;
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      wd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      apply(($urandom_range(0, 24) != 0), a1, a2, wd, $urandom_range(0, 1) == 1, DW'($urandom));
      e1 = visible(a1);
      e2 = visible(a2);
      run_vec($sformatf("rand%0d", n), e1, e2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msrv32_integer_file.md
Name: msrv32_integer_file

Overview:
- RV32I integer register file (x0..x31) sitting directly downstream of the write-enable generator.
- Its write port is qualified by wr_en_integer_file_out, so flushed instructions never commit.
- Provides two asynchronous read ports (rs1, rs2) to the decode/execute path.
- Provides one synchronous write port from the write-back mux, with same-cycle write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, width of each register and of the read/write data ports.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk_in  input  1  core clock; all state updates on rising edge.
- rst_n_in  input  1  synchronous, active-low reset (sampled on rising edge of clk_in).
- rs_1_addr_in  input  ADDR_WIDTH  source register 1 index.
- rs_2_addr_in  input  ADDR_WIDTH  source register 2 index.
- rd_addr_in  input  ADDR_WIDTH  destination register index.
- wr_en_in  input  1  write enable; driven by wr_en_integer_file_out of the write-enable generator.
- rd_in  input  DATA_WIDTH  write-back data.
- rs_1_out  output  DATA_WIDTH  read data for rs1.
- rs_2_out  output  DATA_WIDTH  read data for rs2.

Behaviour:
- Storage: array reg_file[1..NUM_REGS-1] of DATA_WIDTH flops. No storage exists for x0.
- Reset:
  - Rising edge with rst_n_in=0 clears every entry to 0.
  - Reset has priority over a coincident write; that write is discarded.
- Write:
  - Rising edge with rst_n_in=1, wr_en_in=1 and rd_addr_in!=0 loads reg_file[rd_addr_in] <= rd_in.
  - Write latency 1 cycle: the array value is visible on the next cycle.
  - rd_addr_in==0 with wr_en_in=1 is a no-op; no entry changes.
  - wr_en_in=0: no entry changes, regardless of rd_addr_in or rd_in.
- Read (combinational, zero latency), evaluated independently per port p in {1,2}:
  - Priority 1: rst_n_in=0 -> rs_p_out = 0.
  - Priority 2: rs_p_addr_in==0 -> rs_p_out = 0, even if a write to 0 is requested.
  - Priority 3: wr_en_in=1 and rd_addr_in==rs_p_addr_in -> rs_p_out = rd_in (bypass).
  - Priority 4: otherwise rs_p_out = reg_file[rs_p_addr_in].
- Both ports may address the same register; both return identical data, including the bypass value.
- Reset values of outputs: 0 on both ports for the whole time rst_n_in is low.
  - After reset release, all reads return 0 until written.
- Reset mid-operation:
  - A write presented in the same cycle as reset is lost.
  - Values written before reset are cleared.
- No X propagation: all addresses are in range by construction (NUM_REGS = 2**ADDR_WIDTH).
- Implementation constraints:
  - Pure synchronous logic; no latches.
  - The read path must not pass through any flop.

Test Plan:
- Reset then read: hold rst_n_in=0 for 2 cycles, release, read rs1=5 and rs2=31 -> both outputs 0x00000000; while reset is low, outputs are 0 for any address.
- Write/read-back: write x5=0xDEADBEEF (wr_en_in=1) in cycle n. In cycle n+1 with wr_en_in=0, rs1=5 -> 0xDEADBEEF and rs2=6 -> 0x00000000.
- x0 hardwiring: wr_en_in=1, rd=0, rd_in=0xFFFFFFFF. Same cycle and next cycle, rs1=rs2=0 -> 0x00000000.
- Bypass: x7 holds 0x11111111. Drive wr_en_in=1, rd=7, rd_in=0x22222222, rs1=7, rs2=7 -> both outputs 0x22222222 in the same cycle. Repeat with wr_en_in=0 (flushed write) -> both outputs 0x11111111, and x7 stays 0x11111111 next cycle.
- Reset vs write collision: x3=0xA5A5A5A5 stored. Cycle with rst_n_in=0, wr_en_in=1, rd=3, rd_in=0x12345678. After release, rs1=3 -> 0x00000000.
- Full sweep: write x1..x31 with value (index<<24)|index, then read all pairs (i, 32-i) -> each port returns its own pattern, e.g. rs1=1 -> 0x01000001, rs2=31 -> 0x1F00001F.
